tft_timing_gen: RTL and testbench

- Raster timing generator for the TFT-LCD path.
- Produces Hsync, Vsync, DE, H_COUNT/V_COUNT and active-area pixel coordinates, advancing one pixel per pixel-enable pulse.
- Sits directly upstream of the TFT-LCD controller/BRAM controller, which consume its Hsync/Vsync/DE and pixel coordinates to fetch and gate R/G/B.

---
 rtl/tft_timing_pkg.sv | 34 +++
 rtl/tft_timing_gen_if.sv | 35 +++
 rtl/tft_axis_counter.sv | 66 ++++++
 rtl/tft_timing_gen.sv | 99 +++++++++
 tb/tb_tft_timing_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/tft_timing_pkg.sv
// Default 480x272 panel timing, counter width and colour-bar table for the TFT raster generator.
// The colour-bar table is only consumed when TFT_TEST_PATTERN_EN is defined.
package tft_timing_pkg;

  localparam int DEF_CW       = 10;
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BACK   = 2;
  localparam int DEF_H_FRONT  = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BACK   = 2;
  localparam int DEF_V_FRONT  = 2;

  function automatic int axis_total(input int active, input int sync,
                                    input int back, input int front);
    return active + sync + back + front;
  endfunction

  function automatic int h_total();
    return axis_total(DEF_H_ACTIVE, DEF_H_SYNC, DEF_H_BACK, DEF_H_FRONT);
  endfunction

  function automatic int v_total();
    return axis_total(DEF_V_ACTIVE, DEF_V_SYNC, DEF_V_BACK, DEF_V_FRONT);
  endfunction

  // {R,G,B} per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB [0:7] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/tft_timing_gen_if.sv
// Timing bus between the raster generator (master) and the LCD/BRAM controller (slave).
// R/G/B exist only when TFT_TEST_PATTERN_EN is defined.
interface tft_timing_gen_if
  import tft_timing_pkg::*;
#(
  parameter int CW = DEF_CW
);

  logic          pix_en;
  logic [CW-1:0] H_COUNT;
  logic [CW-1:0] V_COUNT;
  logic          Hsync;
  logic          Vsync;
  logic          DE;
  logic [CW-1:0] px_x;
  logic [CW-1:0] px_y;
  logic          frame_start;

`ifdef TFT_TEST_PATTERN_EN
  logic [7:0]    R;
  logic [7:0]    G;
  logic [7:0]    B;

  modport master (input pix_en, output H_COUNT, V_COUNT, Hsync, Vsync, DE,
                  px_x, px_y, frame_start, R, G, B);
  modport slave  (output pix_en, input H_COUNT, V_COUNT, Hsync, Vsync, DE,
                  px_x, px_y, frame_start, R, G, B);
`else
  modport master (input pix_en, output H_COUNT, V_COUNT, Hsync, Vsync, DE,
                  px_x, px_y, frame_start);
  modport slave  (output pix_en, input H_COUNT, V_COUNT, Hsync, Vsync, DE,
                  px_x, px_y, frame_start);
`endif

endinterface

// File: rtl/tft_axis_counter.sv
// One raster axis: wrapping position counter ordered sync, back porch, active, front porch.
// Sync is registered here; active/coord are next-state decodes so the parent registers them in step.
module tft_axis_counter
  import tft_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int CW     = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          adv_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o,
  output logic          sync_n_o,
  output logic          active_d_o,
  output logic [CW-1:0] coord_d_o
);

  localparam int TOTAL = axis_total(ACTIVE, SYNC, BACK, FRONT);

  if (TOTAL > (1 << CW)) begin : g_width_fail
    $error("tft_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
  end

  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
  localparam logic [CW-1:0] ACT_LO   = CW'(SYNC + BACK);
  localparam logic [CW-1:0] ACT_HI   = CW'(SYNC + BACK + ACTIVE - 1);

  logic [CW-1:0] count_q, count_d;
  logic          sync_n_q, sync_n_d;

  always_comb begin
    wrap_o  = adv_i && (count_q == LAST);
    count_d = count_q;
    if (wrap_o) begin
      count_d = '0;
    end else if (adv_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Decodes are taken from the next count so they land on the same edge as the count itself
  always_comb begin
    sync_n_d   = (count_d >= SYNC_END);
    active_d_o = (count_d >= ACT_LO) && (count_d <= ACT_HI);
    coord_d_o  = active_d_o ? (count_d - ACT_LO) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= LAST;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count_o  = count_q;
  assign sync_n_o = sync_n_q;

endmodule

// File: rtl/tft_timing_gen.sv
// Raster timing generator for the TFT-LCD path: counts, syncs, DE and active-area coordinates.
// Define TFT_TEST_PATTERN_EN to add registered eight-bar R/G/B colour outputs.
module tft_timing_gen
  import tft_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int CW       = DEF_CW
) (
  input  logic             CLK,
  input  logic             nRESET,
  tft_timing_gen_if.master bus
);

  logic          h_wrap, h_sync_n, h_act_d;
  logic          v_wrap, v_sync_n, v_act_d;
  logic [CW-1:0] h_cnt, h_coord_d, v_cnt, v_coord_d;

  tft_axis_counter #(
    .ACTIVE(H_ACTIVE), .SYNC(H_SYNC), .BACK(H_BACK), .FRONT(H_FRONT), .CW(CW)
  ) u_h_axis (
    .clk_i(CLK), .rst_ni(nRESET), .adv_i(bus.pix_en),
    .count_o(h_cnt), .wrap_o(h_wrap), .sync_n_o(h_sync_n),
    .active_d_o(h_act_d), .coord_d_o(h_coord_d)
  );

  tft_axis_counter #(
    .ACTIVE(V_ACTIVE), .SYNC(V_SYNC), .BACK(V_BACK), .FRONT(V_FRONT), .CW(CW)
  ) u_v_axis (
    .clk_i(CLK), .rst_ni(nRESET), .adv_i(h_wrap),
    .count_o(v_cnt), .wrap_o(v_wrap), .sync_n_o(v_sync_n),
    .active_d_o(v_act_d), .coord_d_o(v_coord_d)
  );

  logic          de_q, de_d;
  logic [CW-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic          fs_q;

  always_comb begin
    de_d   = h_act_d && v_act_d;
    px_x_d = de_d ? h_coord_d : '0;
    px_y_d = de_d ? v_coord_d : '0;
  end

  // A vertical wrap is exactly the advance that lands on (0,0), and it is never set while holding
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      de_q   <= 1'b0;
      px_x_q <= '0;
      px_y_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      de_q   <= de_d;
      px_x_q <= px_x_d;
      px_y_q <= px_y_d;
      fs_q   <= v_wrap;
    end
  end

  assign bus.H_COUNT     = h_cnt;
  assign bus.V_COUNT     = v_cnt;
  assign bus.Hsync       = h_sync_n;
  assign bus.Vsync       = v_sync_n;
  assign bus.DE          = de_q;
  assign bus.px_x        = px_x_q;
  assign bus.px_y        = px_y_q;
  assign bus.frame_start = fs_q;

`ifdef TFT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    bar_idx = 3'(px_x_d / CW'(BAR_W));
    rgb_d   = de_d ? BAR_RGB[bar_idx] : 24'h000000;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign bus.R = rgb_q[23:16];
  assign bus.G = rgb_q[15:8];
  assign bus.B = rgb_q[7:0];
`endif

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen: default 480x272 instance plus a tiny-geometry instance for frame wrap,
// both checked every cycle against a linear pixel-index model; RGB checked when TFT_TEST_PATTERN_EN.
module tb_tft_timing_gen;

  typedef struct {
    int ha, hs, hb, hf;
    int va, vs, vb, vf;
  } geom_t;

`ifdef TFT_TEST_PATTERN_EN
  localparam int OBS_W = 68;
`else
  localparam int OBS_W = 44;
`endif

  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  always #5 CLK = ~CLK;

  tft_timing_gen_if busA ();
  tft_timing_gen_if busB ();

  tft_timing_gen dutA (.CLK(CLK), .nRESET(nRESET), .bus(busA));

  tft_timing_gen #(
    .H_ACTIVE(8), .H_SYNC(3), .H_BACK(2), .H_FRONT(2),
    .V_ACTIVE(4), .V_SYNC(2), .V_BACK(1), .V_FRONT(1)
  ) dutB (.CLK(CLK), .nRESET(nRESET), .bus(busB));

  logic [OBS_W-1:0] obsA, obsB;
`ifdef TFT_TEST_PATTERN_EN
  assign obsA = {busA.H_COUNT, busA.V_COUNT, busA.Hsync, busA.Vsync, busA.DE,
                 busA.px_x, busA.px_y, busA.frame_start, busA.R, busA.G, busA.B};
  assign obsB = {busB.H_COUNT, busB.V_COUNT, busB.Hsync, busB.Vsync, busB.DE,
                 busB.px_x, busB.px_y, busB.frame_start, busB.R, busB.G, busB.B};
`else
  assign obsA = {busA.H_COUNT, busA.V_COUNT, busA.Hsync, busA.Vsync, busA.DE,
                 busA.px_x, busA.px_y, busA.frame_start};
  assign obsB = {busB.H_COUNT, busB.V_COUNT, busB.Hsync, busB.Vsync, busB.DE,
                 busB.px_x, busB.px_y, busB.frame_start};
`endif

  geom_t gA, gB;
  int    posA, posB;
  bit    fsA, fsB;
  int    compared = 0;
  int    mismatched = 0;

  function automatic int frameLen(input geom_t g);
    return (g.ha + g.hs + g.hb + g.hf) * (g.va + g.vs + g.vb + g.vf);
  endfunction

  // Model position is the pixel index within the frame; everything else is derived arithmetically
  function automatic logic [OBS_W-1:0] refVec(input geom_t g, input int pos, input bit fs);
    int ht, h, v, hLo, vLo, px, py;
    bit de;
    logic [43:0] base;
    ht  = g.ha + g.hs + g.hb + g.hf;
    h   = pos % ht;
    v   = pos / ht;
    hLo = g.hs + g.hb;
    vLo = g.vs + g.vb;
    de  = (h >= hLo) && (h < hLo + g.ha) && (v >= vLo) && (v < vLo + g.va);
    px  = de ? h - hLo : 0;
    py  = de ? v - vLo : 0;
    base = {10'(h), 10'(v), (h >= g.hs), (v >= g.vs), de, 10'(px), 10'(py), fs};
`ifdef TFT_TEST_PATTERN_EN
    begin
      int idx;
      logic [23:0] rgb;
      idx = px / (g.ha / 8);
      rgb = 24'h0;
      if (de) begin
        rgb[23:16] = ((idx & 2) == 0) ? 8'hFF : 8'h00;
        rgb[15:8]  = (idx < 4)        ? 8'hFF : 8'h00;
        rgb[7:0]   = ((idx & 1) == 0) ? 8'hFF : 8'h00;
      end
      return {base, rgb};
    end
`else
    return base;
`endif
  endfunction

  function automatic int nextPos(input int pos, input int len, input bit rst, input bit en);
    if (!rst) return len - 1;
    if (en)   return (pos + 1) % len;
    return pos;
  endfunction

  task automatic checkOutput();
    logic [OBS_W-1:0] expA, expB;
    expA = refVec(gA, posA, fsA);
    expB = refVec(gB, posB, fsB);
    compared++;
    assert (obsA === expA) else begin
      mismatched++;
      $error("[TB] FAIL rasterA t=%0t observed=%h expected=%h", $time, obsA, expA);
    end
    compared++;
    assert (obsB === expB) else begin
      mismatched++;
      $error("[TB] FAIL rasterB t=%0t observed=%h expected=%h", $time, obsB, expB);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en);
    nRESET      = rst;
    busA.pix_en = en;
    busB.pix_en = en;
    @(posedge CLK);
    #1;
    posA = nextPos(posA, frameLen(gA), rst, en);
    posB = nextPos(posB, frameLen(gB), rst, en);
    fsA  = rst && en && (posA == 0);
    fsB  = rst && en && (posB == 0);
    checkOutput();
  endtask

  task automatic checkOrigin(input string tag);
    compared++;
    assert ({busA.H_COUNT, busA.V_COUNT, busA.Hsync, busA.Vsync, busA.frame_start, busA.DE}
            === {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0}) else begin
      mismatched++;
      $error("[TB] FAIL %s observed H=%0d V=%0d Hs=%b Vs=%b fs=%b DE=%b expected H=0 V=0 Hs=0 Vs=0 fs=1 DE=0",
             tag, busA.H_COUNT, busA.V_COUNT, busA.Hsync, busA.Vsync, busA.frame_start, busA.DE);
    end
  endtask

  initial begin
    int hsLow0, de0, de12, firstH, firstPx, firstPy, lastH, lastPx;
    int deBefore, fsFirst, fsSecond, vsLowB, fsCountA;

    gA = '{480, 41, 2, 2, 272, 10, 2, 2};
    gB = '{8, 3, 2, 2, 4, 2, 1, 1};
    posA = 0; posB = 0; fsA = 0; fsB = 0;
    busA.pix_en = 1'b0;
    busB.pix_en = 1'b0;

    $display("[TB] reset and first pixel");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOrigin("first_pixel");

    $display("[TB] continuous pix_en through line 12");
    hsLow0 = (busA.Hsync == 1'b0) ? 1 : 0;
    de0 = 0; de12 = 0; firstH = -1; firstPx = -1; firstPy = -1; lastH = -1; lastPx = -1;
    for (int i = 0; i < 13 * 525; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (busA.V_COUNT == 10'd0) begin
        if (busA.Hsync == 1'b0) hsLow0++;
        if (busA.DE) de0++;
      end
      if (busA.V_COUNT == 10'd12 && busA.DE) begin
        de12++;
        if (firstH < 0) begin
          firstH = int'(busA.H_COUNT); firstPx = int'(busA.px_x); firstPy = int'(busA.px_y);
        end
        lastH = int'(busA.H_COUNT); lastPx = int'(busA.px_x);
      end
    end
    checkValue("hsync_low_line0", hsLow0, 41);
    checkValue("de_line0", de0, 0);
    checkValue("de_count_line12", de12, 480);
    checkValue("first_de_hcount", firstH, 43);
    checkValue("first_de_px_x", firstPx, 0);
    checkValue("first_de_px_y", firstPy, 0);
    checkValue("last_de_hcount", lastH, 522);
    checkValue("last_de_px_x", lastPx, 479);

    $display("[TB] toggling pix_en then mid-active reset");
    for (int i = 0; i < 120; i++) applyStimulus(1'b1, i[0] == 1'b0);
    deBefore = busA.DE ? 1 : 0;
    checkValue("de_before_reset", deBefore, 1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOrigin("restart_after_reset");

    $display("[TB] randomized pix_en and occasional reset");
    for (int i = 0; i < 6000; i++) begin
      applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] frame period on small geometry");
    applyStimulus(1'b0, 1'b1);
    fsFirst = -1; fsSecond = -1; vsLowB = 0; fsCountA = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (busA.frame_start) fsCountA++;
      if (busB.frame_start) begin
        if (fsFirst < 0) fsFirst = i;
        else if (fsSecond < 0) fsSecond = i;
      end
      if (fsFirst >= 0 && fsSecond < 0 && busB.Vsync == 1'b0) vsLowB++;
    end
    checkValue("frame_period_small", (fsFirst >= 0 && fsSecond >= 0) ? fsSecond - fsFirst : -1, 120);
    checkValue("vsync_low_small", vsLowB, 30);
    checkValue("frame_start_pulses_default", fsCountA, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
